ysyx_bus_arb: RTL and testbench
===============================

Name: ysyx_bus_arb

Overview:
- Shares the single core memory master port between the instruction-fetch unit (L1I refill reads) and the load/store unit (reads and writes).
- Sits between the IFU/LSU and the SoC AXI4-lite-style master interface.
- Serialises all accesses: one outstanding transaction at a time.
- Enforces IFU refill locking, LSU priority and a response watchdog.

Parameters:
- DATA_W, 32, address/data width.
- TIMEOUT, 1023, cycles to wait for arready/rvalid/awready/wready/bvalid before aborting with error; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ifu_araddr  in  DATA_W  IFU read address, word aligned.
- ifu_arvalid  in  1  IFU read request; level, held until served.
- ifu_required  in  1  IFU refill in progress; locks the bus to the IFU.
- ifu_rdata_o  out  DATA_W  read data to IFU.
- ifu_rvalid_o  out  1  one-cycle pulse, ifu_rdata_o valid.
- lsu_araddr  in  DATA_W  LSU read address.
- lsu_arvalid  in  1  LSU read request; level.
- lsu_awaddr  in  DATA_W  LSU write address.
- lsu_awvalid  in  1  LSU write request; level; wdata/wstrb are stable with it.
- lsu_wdata  in  DATA_W  write data.
- lsu_wstrb  in  DATA_W/8  write byte strobes.
- lsu_rdata_o  out  DATA_W  read data to LSU.
- lsu_rvalid_o  out  1  one-cycle pulse, LSU read done.
- lsu_bvalid_o  out  1  one-cycle pulse, LSU write done.
- bus_araddr_o, bus_arvalid_o, bus_arready  out/out/in  DATA_W/1/1  AR channel.
- bus_rdata, bus_rresp, bus_rvalid, bus_rready_o  in/in/in/out  DATA_W/2/1/1  R channel.
- bus_awaddr_o, bus_awvalid_o, bus_awready  out/out/in  DATA_W/1/1  AW channel.
- bus_wdata_o, bus_wstrb_o, bus_wvalid_o, bus_wready  out/out/out/in  DATA_W/DATA_W/8/1/1  W channel.
- bus_bresp, bus_bvalid, bus_bready_o  in/in/out  2/1/1  B channel.
- bus_err_o  out  1  sticky error flag (resp!=0 or timeout); cleared only by rst.

Behaviour:
- States: IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_W, LSU_B.
- Reset: state=IDLE, lock=0, watchdog=0. All valid/ready outputs 0, bus_err_o=0, data/address outputs 0.
- Grant from IDLE, evaluated every cycle, priority highest first:
  - (1) lock & ifu_arvalid -> IFU_AR.
  - (2) lock & ifu_required & !ifu_arvalid -> stay IDLE; LSU blocked.
  - (3) lsu_awvalid -> LSU_W.
  - (4) lsu_arvalid -> LSU_AR.
  - (5) ifu_arvalid -> IFU_AR.
- Latch on grant: the granted address (and wdata/wstrb for writes) is registered in the grant cycle. Bus valid asserts the following cycle, so there is 1 cycle of arbitration latency.
- IFU_AR / LSU_AR:
  - bus_arvalid_o=1 with the latched address.
  - On bus_arready, go to *_R.
- IFU_R / LSU_R:
  - bus_rready_o=1.
  - On bus_rvalid, forward bus_rdata combinationally to the requester's rdata_o and pulse its rvalid_o that same cycle, then go to IDLE.
  - rresp!=0 sets bus_err_o; data is still delivered.
- LSU_W:
  - bus_awvalid_o and bus_wvalid_o both asserted.
  - Each deasserts independently once its own ready has been seen.
  - Go to LSU_B when both handshakes are done, including same cycle or either order.
- LSU_B: bus_bready_o=1. On bus_bvalid, pulse lsu_bvalid_o and go to IDLE. bresp!=0 sets bus_err_o.
- Lock:
  - Set on completion of an IFU_R beat while ifu_required=1.
  - Cleared in any cycle where ifu_required=0.
  - Guarantees both beats of a 2-beat L1I line refill are back-to-back with no LSU interleave, including the IFU's idle gap cycle between beats.
- Watchdog:
  - Counter resets on every state change.
  - Increments each cycle spent in a non-IDLE state.
  - On reaching TIMEOUT: set bus_err_o, deassert all bus valids/readies, pulse the owner's completion signal with rdata=0, go to IDLE, clear lock.
- Simultaneous events:
  - LSU write and read both requested: write wins.
  - Request arriving while busy waits; no queueing beyond the held level.
  - A requester dropping valid after grant does not cancel the transaction.
- rst mid-transaction: state returns to IDLE next edge and the in-flight transaction is abandoned; the SoC is reset together.
- Outputs rvalid_o/bvalid_o are never high for more than one cycle per transaction.

Test Plan:
- IFU read 0x30000000, slave arready after 2 cycles, rvalid after 3 with 0x00000413 -> bus_arvalid_o rises 1 cycle after request; ifu_rvalid_o pulses once with 0x00000413; state back in IDLE.
- ifu_arvalid and lsu_arvalid asserted in the same cycle, lock=0 -> LSU served first (bus_araddr_o=lsu address), then IFU; two separate rvalid pulses.
- IFU 2-beat refill (0x80000000 then 0x80000004, ifu_required high throughout, 1-cycle gap) with lsu_awvalid raised during the gap -> both IFU beats complete before bus_awvalid_o asserts.
- LSU write 0xdeadbeef, wstrb=0xF, awready 1 cycle before wready -> awvalid drops first, wvalid held until wready; lsu_bvalid_o pulses once after bvalid.
- Slave never responds, TIMEOUT=16 -> after 16 cycles bus_err_o=1, requester sees a completion pulse with data 0, next request is accepted normally.
- rst asserted while in LSU_R -> next cycle all outputs 0, state IDLE, bus_err_o 0.

Source files
------------

// File: rtl/ysyx_bus_arb_if.sv
// Core-side AXI4-lite style master port shared by the IFU and LSU.
interface ysyx_bus_arb_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;
   logic [DATA_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/ysyx_bus_arb.sv
// IFU/LSU arbiter for the single core memory master port: one transaction
// in flight, IFU refill lock, LSU priority and a response watchdog.
module ysyx_bus_arb #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   ifu_araddr,
   input  logic                ifu_arvalid,
   input  logic                ifu_required,
   output logic [DATA_W-1:0]   ifu_rdata_o,
   output logic                ifu_rvalid_o,
   input  logic [DATA_W-1:0]   lsu_araddr,
   input  logic                lsu_arvalid,
   input  logic [DATA_W-1:0]   lsu_awaddr,
   input  logic                lsu_awvalid,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wstrb,
   output logic [DATA_W-1:0]   lsu_rdata_o,
   output logic                lsu_rvalid_o,
   output logic                lsu_bvalid_o,
   ysyx_bus_arb_if.master      bus,
   output logic                bus_err_o
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_IFU_AR = 3'd1;
   localparam logic [2:0] S_IFU_R  = 3'd2;
   localparam logic [2:0] S_LSU_AR = 3'd3;
   localparam logic [2:0] S_LSU_R  = 3'd4;
   localparam logic [2:0] S_LSU_W  = 3'd5;
   localparam logic [2:0] S_LSU_B  = 3'd6;

   localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [2:0]          state_q, state_d;
   logic                lock_q, lock_d;
   logic [WD_W-1:0]     wdog_q, wdog_d;
   logic [DATA_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
   logic                aw_done_q, aw_done_d;
   logic                w_done_q, w_done_d;
   logic                err_q, err_d;
   logic                timeout;

   assign timeout   = (TIMEOUT != 0) && (wdog_q == WD_W'(TIMEOUT));
   assign bus_err_o = err_q;

   // Grant, channel sequencing, completion pulses, lock and watchdog.
   always_comb begin
      state_d      = state_q;
      lock_d       = lock_q & ifu_required;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      err_d        = err_q;
      ifu_rdata_o  = '0;
      ifu_rvalid_o = 1'b0;
      lsu_rdata_o  = '0;
      lsu_rvalid_o = 1'b0;
      lsu_bvalid_o = 1'b0;
      bus.araddr   = addr_q;
      bus.arvalid  = 1'b0;
      bus.rready   = 1'b0;
      bus.awaddr   = addr_q;
      bus.awvalid  = 1'b0;
      bus.wdata    = wdata_q;
      bus.wstrb    = wstrb_q;
      bus.wvalid   = 1'b0;
      bus.bready   = 1'b0;

      if (state_q != S_IDLE && timeout) begin
         // Abort: all bus handshakes drop, owner gets a zero-data completion.
         err_d   = 1'b1;
         lock_d  = 1'b0;
         state_d = S_IDLE;
         case (state_q)
            S_IFU_AR, S_IFU_R: ifu_rvalid_o = 1'b1;
            S_LSU_AR, S_LSU_R: lsu_rvalid_o = 1'b1;
            default:           lsu_bvalid_o = 1'b1;
         endcase
      end else begin
         case (state_q)
            S_IDLE: begin
               if (lock_q && ifu_arvalid) begin
                  state_d = S_IFU_AR;
                  addr_d  = ifu_araddr;
               end else if (lock_q && ifu_required) begin
                  state_d = S_IDLE;
               end else if (lsu_awvalid) begin
                  state_d   = S_LSU_W;
                  addr_d    = lsu_awaddr;
                  wdata_d   = lsu_wdata;
                  wstrb_d   = lsu_wstrb;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
               end else if (lsu_arvalid) begin
                  state_d = S_LSU_AR;
                  addr_d  = lsu_araddr;
               end else if (ifu_arvalid) begin
                  state_d = S_IFU_AR;
                  addr_d  = ifu_araddr;
               end
            end
            S_IFU_AR, S_LSU_AR: begin
               bus.arvalid = 1'b1;
               if (bus.arready) state_d = (state_q == S_IFU_AR) ? S_IFU_R : S_LSU_R;
            end
            S_IFU_R, S_LSU_R: begin
               bus.rready = 1'b1;
               if (bus.rvalid) begin
                  state_d = S_IDLE;
                  if (bus.rresp != 2'b00) err_d = 1'b1;
                  if (state_q == S_IFU_R) begin
                     ifu_rdata_o  = bus.rdata;
                     ifu_rvalid_o = 1'b1;
                     lock_d       = ifu_required;
                  end else begin
                     lsu_rdata_o  = bus.rdata;
                     lsu_rvalid_o = 1'b1;
                  end
               end
            end
            S_LSU_W: begin
               // AW and W complete independently; move on once both are done.
               bus.awvalid = !aw_done_q;
               bus.wvalid  = !w_done_q;
               aw_done_d   = aw_done_q | bus.awready;
               w_done_d    = w_done_q | bus.wready;
               if (aw_done_d && w_done_d) state_d = S_LSU_B;
            end
            S_LSU_B: begin
               bus.bready = 1'b1;
               if (bus.bvalid) begin
                  lsu_bvalid_o = 1'b1;
                  state_d      = S_IDLE;
                  if (bus.bresp != 2'b00) err_d = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      if (state_d != state_q || state_q == S_IDLE) wdog_d = '0;
      else                                         wdog_d = wdog_q + 1'b1;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         lock_q    <= 1'b0;
         wdog_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         lock_q    <= lock_d;
         wdog_q    <= wdog_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_ysyx_bus_arb.sv
// Bench for ysyx_bus_arb: directed scenarios plus randomized request mixes,
// with the bench acting as both requesters and the SoC slave.
module tb_ysyx_bus_arb;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata;
   logic        ifu_arvalid, ifu_required, lsu_arvalid, lsu_awvalid;
   logic [3:0]  lsu_wstrb;
   logic [31:0] ifu_rdata_o, lsu_rdata_o;
   logic        ifu_rvalid_o, lsu_rvalid_o, lsu_bvalid_o, bus_err_o;

   always #5 clk = ~clk;

   ysyx_bus_arb_if #(.DATA_W(32)) bus_if ();

   ysyx_bus_arb #(.DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_required(ifu_required),
      .ifu_rdata_o(ifu_rdata_o), .ifu_rvalid_o(ifu_rvalid_o),
      .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid),
      .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid),
      .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
      .lsu_rdata_o(lsu_rdata_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_bvalid_o(lsu_bvalid_o),
      .bus(bus_if), .bus_err_o(bus_err_o)
   );

   int nvec = 0;
   int nerr = 0;

   // Reference state: slave memory, outstanding request levels, refill lock.
   logic [31:0] mem [logic [31:0]];
   bit ifu_pend, lsr_pend, lsw_pend, lock_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rd_mem(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   // Who the arbiter must serve next: locked IFU, then write, LSU read, IFU.
   function automatic int exp_owner();
      if (lock_m && ifu_pend) return 0;
      if (lsw_pend) return 2;
      if (lsr_pend) return 1;
      return 0;
   endfunction

   task automatic req_ifu(input logic [31:0] a);
      ifu_araddr = a; ifu_arvalid = 1'b1; ifu_pend = 1'b1;
   endtask

   task automatic req_lr(input logic [31:0] a);
      lsu_araddr = a; lsu_arvalid = 1'b1; lsr_pend = 1'b1;
   endtask

   task automatic req_lw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      lsu_awaddr = a; lsu_wdata = d; lsu_wstrb = s; lsu_awvalid = 1'b1; lsw_pend = 1'b1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valids"}, 32'({bus_if.arvalid, bus_if.rready, bus_if.awvalid, bus_if.wvalid,
                                  bus_if.bready, ifu_rvalid_o, lsu_rvalid_o, lsu_bvalid_o}), 32'd0);
      chk({tag, "_araddr"}, bus_if.araddr, 32'd0);
      chk({tag, "_awaddr"}, bus_if.awaddr, 32'd0);
      chk({tag, "_wdata"}, bus_if.wdata, 32'd0);
      chk({tag, "_wstrb"}, 32'(bus_if.wstrb), 32'd0);
      chk({tag, "_err"}, 32'(bus_err_o), 32'd0);
   endtask

   // Wait for the next bus transaction, check it belongs to the expected owner,
   // and complete it as the slave. d0/d1/d2 are AR/R or AW/W/B delays.
   task automatic serve(input int lat_exp, input int d0, input int d1, input int d2,
                        input logic [1:0] resp);
      int lat, own, mx;
      logic [31:0] a, d, v;
      lat = 0;
      while (!(bus_if.arvalid || bus_if.awvalid) && lat < 40) begin
         @(negedge clk); #1; lat++;
      end
      chk("grant_latency", 32'(lat), 32'(lat_exp));
      own = exp_owner();
      chk("grant_kind", 32'({bus_if.awvalid, bus_if.arvalid}), (own == 2) ? 32'd2 : 32'd1);
      if (own != 2) begin
         a = (own == 0) ? ifu_araddr : lsu_araddr;
         d = rd_mem(a);
         chk("araddr", bus_if.araddr, a);
         repeat (d0) begin @(negedge clk); #1; chk("ar_hold", 32'(bus_if.arvalid), 32'd1); end
         bus_if.arready = 1'b1;
         @(negedge clk); bus_if.arready = 1'b0; #1;
         chk("ar_done", 32'({bus_if.arvalid, bus_if.rready}), 32'd1);
         repeat (d1) begin
            @(negedge clk); #1;
            chk("r_wait", 32'({bus_if.rready, ifu_rvalid_o, lsu_rvalid_o}), 32'd4);
         end
         bus_if.rvalid = 1'b1; bus_if.rdata = d; bus_if.rresp = resp; #1;
         chk("r_pulse", 32'({ifu_rvalid_o, lsu_rvalid_o}), (own == 0) ? 32'd2 : 32'd1);
         chk("r_data", (own == 0) ? ifu_rdata_o : lsu_rdata_o, d);
         if (own == 0) begin
            ifu_arvalid = 1'b0; ifu_pend = 1'b0;
            if (ifu_required) lock_m = 1'b1;
         end else begin
            lsu_arvalid = 1'b0; lsr_pend = 1'b0;
         end
         @(negedge clk); bus_if.rvalid = 1'b0; bus_if.rresp = 2'b00; #1;
         chk("r_end", 32'({bus_if.arvalid, bus_if.rready, ifu_rvalid_o, lsu_rvalid_o}), 32'd0);
      end else begin
         a = lsu_awaddr;
         chk("awaddr", bus_if.awaddr, lsu_awaddr);
         chk("wdata", bus_if.wdata, lsu_wdata);
         chk("wstrb", 32'(bus_if.wstrb), 32'(lsu_wstrb));
         mx = (d0 > d1) ? d0 : d1;
         for (int k = 0; k <= mx; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            chk("aw_w_valid", 32'({bus_if.awvalid, bus_if.wvalid}), 32'({k <= d0, k <= d1}));
            bus_if.awready = (k == d0);
            bus_if.wready  = (k == d1);
         end
         @(negedge clk); bus_if.awready = 1'b0; bus_if.wready = 1'b0; #1;
         chk("w_done", 32'({bus_if.awvalid, bus_if.wvalid, bus_if.bready}), 32'd1);
         repeat (d2) begin
            @(negedge clk); #1;
            chk("b_wait", 32'({bus_if.bready, lsu_bvalid_o}), 32'd2);
         end
         bus_if.bvalid = 1'b1; bus_if.bresp = resp; #1;
         chk("b_pulse", 32'(lsu_bvalid_o), 32'd1);
         v = rd_mem(a);
         for (int b = 0; b < 4; b++) if (lsu_wstrb[b]) v[8*b +: 8] = lsu_wdata[8*b +: 8];
         mem[a] = v;
         lsu_awvalid = 1'b0; lsw_pend = 1'b0;
         @(negedge clk); bus_if.bvalid = 1'b0; bus_if.bresp = 2'b00; #1;
         chk("b_end", 32'({bus_if.bready, lsu_bvalid_o}), 32'd0);
      end
   endtask

   task automatic serve_rand();
      serve(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 2'b00);
   endtask

   initial begin
      #500000;
      $display("FAIL tb_timeout: observed no end expected $finish");
      $fatal(1);
   end

   initial begin
      int hi, m;
      rst = 1'b1;
      ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_required = 1'b0;
      lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_awaddr = '0; lsu_awvalid = 1'b0;
      lsu_wdata = '0; lsu_wstrb = '0;
      bus_if.arready = 1'b0; bus_if.rdata = '0; bus_if.rresp = 2'b00; bus_if.rvalid = 1'b0;
      bus_if.awready = 1'b0; bus_if.wready = 1'b0; bus_if.bresp = 2'b00; bus_if.bvalid = 1'b0;
      ifu_pend = 0; lsr_pend = 0; lsw_pend = 0; lock_m = 0;

      // Reset state
      repeat (3) @(negedge clk);
      #1; chk_idle("reset");
      rst = 1'b0;

      // Single IFU read: arready after 2, rvalid after 3
      mem[32'h3000_0000] = 32'h0000_0413;
      req_ifu(32'h3000_0000);
      serve(1, 2, 3, 0, 2'b00);

      // IFU and LSU read together: LSU first
      req_ifu(32'h3000_0004);
      req_lr(32'h2000_0010);
      serve(1, 0, 1, 0, 2'b00);
      serve(1, 1, 0, 0, 2'b00);

      // Locked 2-beat refill with an LSU write raised in the gap
      ifu_required = 1'b1;
      req_ifu(32'h8000_0000);
      serve(1, 1, 1, 0, 2'b00);
      req_lw(32'h2000_0100, 32'hCAFE_F00D, 4'hF);
      chk("gap_aw0", 32'({bus_if.awvalid, bus_if.arvalid}), 32'd0);
      @(negedge clk); #1;
      chk("gap_aw1", 32'({bus_if.awvalid, bus_if.arvalid}), 32'd0);
      req_ifu(32'h8000_0004);
      serve(1, 0, 2, 0, 2'b00);
      ifu_required = 1'b0; lock_m = 1'b0;
      serve(1, 0, 0, 0, 2'b00);

      // Write with awready one cycle before wready
      req_lw(32'h2000_0200, 32'hDEAD_BEEF, 4'hF);
      serve(1, 0, 1, 1, 2'b00);

      // Randomized request mixes
      for (int it = 0; it < 30; it++) begin
         m = int'($urandom_range(1, 7));
         if (m[0]) req_ifu(32'h8000_0000 + ($urandom_range(0, 63) << 2));
         if (m[1]) req_lr(32'h2000_0000 + ($urandom_range(0, 7) << 2));
         if (m[2]) req_lw(32'h2000_0000 + ($urandom_range(0, 7) << 2), $urandom,
                          4'($urandom_range(0, 15)));
         while (ifu_pend || lsr_pend || lsw_pend) serve_rand();
      end
      chk("err_clean", 32'(bus_err_o), 32'd0);

      // Error response sets the sticky flag
      req_lr(32'h2000_0004);
      serve(1, 1, 1, 0, 2'b10);
      chk("err_rresp", 32'(bus_err_o), 32'd1);

      // Reset while in LSU_R
      req_lr(32'h2000_0008);
      @(negedge clk); #1;
      chk("rst_ar", 32'(bus_if.arvalid), 32'd1);
      bus_if.arready = 1'b1;
      @(negedge clk); bus_if.arready = 1'b0; #1;
      chk("rst_in_r", 32'(bus_if.rready), 32'd1);
      rst = 1'b1; lsu_arvalid = 1'b0; lsr_pend = 1'b0;
      @(negedge clk); #1;
      chk_idle("rst_mid");
      rst = 1'b0; lock_m = 1'b0;

      // Silent slave: watchdog abort
      bus_if.rdata = '1;
      req_ifu(32'h3000_0040);
      @(negedge clk); #1;
      chk("wd_grant", 32'(bus_if.arvalid), 32'd1);
      hi = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (!bus_if.arvalid) break;
         hi++;
      end
      chk("wd_cycles", 32'(hi), 32'(TO));
      chk("wd_pulse", 32'({ifu_rvalid_o, lsu_rvalid_o, lsu_bvalid_o}), 32'd4);
      chk("wd_data", ifu_rdata_o, 32'd0);
      ifu_arvalid = 1'b0; ifu_pend = 1'b0;
      @(negedge clk); #1;
      chk("wd_err", 32'({bus_err_o, ifu_rvalid_o}), 32'd2);
      bus_if.rdata = '0;
      req_lr(32'h2000_000C);
      serve(1, 0, 1, 0, 2'b00);
      chk("wd_err_sticky", 32'(bus_err_o), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
